// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Sums COUNT consecutive unsigned 8-bit adder words into an
//               ACC_W-bit block total. The total is presented on a
//               valid/ready output, and the block then clears for the next one.
// Ports       : clk, rst (async, active-high)  - clock and reset
//               clear                          - synchronous block abort
//               in_valid/in_ready/in_data      - 8-bit word input handshake
//               out_valid/out_ready/out_sum    - block total output handshake
//               ovf                            - carry seen in current block
//               sample_cnt                     - words accepted in block
// Options     : SUM_ACCUMULATOR_SAT_EN - saturate on carry instead of wrap
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             ovf,
  output logic [7:0]       sample_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

  // One extra bit of headroom exposes the carry out of the accumulator.
  assign sum_ext  = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_data};
  assign carry    = sum_ext[ACC_W];

`ifdef SUM_ACCUMULATOR_SAT_EN
  // Once pinned at all-ones, any further add carries again, so the value
  // stays saturated for the rest of the block.
  assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clear) begin
      // Abort wins over both a same-cycle accept and an output handshake.
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc_d = acc_add;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == LAST_CNT) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign out_sum    = acc_q;
  assign ovf        = ovf_q;
  assign sample_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Self-checking bench for sum_accumulator. The main instance
//               (ACC_W=9, COUNT=4) is compared each cycle against a block
//               model built from a queue of accepted words. A second instance
//               (COUNT=1) covers single-word blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

  localparam int ACC_W  = 9;
  localparam int COUNT  = 4;
  localparam int C1_W   = 10;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear, in_valid, out_ready;
  logic [7:0]       in_data;
  logic             in_ready, out_valid, ovf;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       sample_cnt;

  logic             c1_clear, c1_in_valid, c1_out_ready;
  logic [7:0]       c1_in_data;
  logic             c1_in_ready, c1_out_valid, c1_ovf;
  logic [C1_W-1:0]  c1_out_sum;
  logic [7:0]       c1_sample_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words accepted in the current block, and whether a
  // completed block is being held for the consumer.
  int m_words[$];
  bit m_held;

  always #5 clk = ~clk;

  sum_accumulator #(.ACC_W(ACC_W), .COUNT(COUNT)) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .ovf(ovf), .sample_cnt(sample_cnt)
  );

  sum_accumulator #(.ACC_W(C1_W), .COUNT(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .clear(c1_clear),
    .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in_data(c1_in_data),
    .out_valid(c1_out_valid), .out_ready(c1_out_ready), .out_sum(c1_out_sum),
    .ovf(c1_ovf), .sample_cnt(c1_sample_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_words.delete();
    m_held = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    int s;
    int exp_sum;
    s = 0;
    foreach (m_words[i]) s += m_words[i];
`ifdef SUM_ACCUMULATOR_SAT_EN
    exp_sum = (s > MAXV) ? MAXV : s;
`else
    exp_sum = s % (MAXV + 1);
`endif
    chk({tag, ".out_valid"}, int'(out_valid), int'(m_held));
    chk({tag, ".in_ready"}, int'(in_ready), int'(!m_held));
    chk({tag, ".sample_cnt"}, int'(sample_cnt), m_words.size());
    chk({tag, ".ovf"}, int'(ovf), int'(s > MAXV));
    if (m_held) chk({tag, ".out_sum"}, int'(out_sum), exp_sum);
  endtask

  // Apply one cycle of inputs to the main DUT, advance the model by the
  // block rules, then compare just after the clock edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic rdy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clear     = clr;
    if (clr) begin
      model_reset();
    end else if (m_held) begin
      if (rdy) model_reset();
    end else if (v) begin
      m_words.push_back(int'(d));
      if (m_words.size() == COUNT) m_held = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    int words1[4];
    words1 = '{10, 20, 30, 40};
    rst = 1'b1;
    clear = 0; in_valid = 0; out_ready = 0; in_data = 0;
    c1_clear = 0; c1_in_valid = 0; c1_out_ready = 0; c1_in_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_sum", int'(out_sum), 0);
    chk("rst.sample_cnt", int'(sample_cnt), 0);
    chk("rst.ovf", int'(ovf), 0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", int'(in_ready), 1);

    // Back-to-back block held with out_ready low, then released.
    foreach (words1[i]) step("t1", 1'b1, 8'(words1[i]), 1'b0, 1'b0);
    chk("t1.sum100", int'(out_sum), 100);
    step("t1.hold", 1'b0, 8'd0, 1'b0, 1'b0);
    step("t1.release", 1'b0, 8'd0, 1'b1, 1'b0);

    // Gapped input, 5 cycles of backpressure with in_valid pushing at DONE.
    foreach (words1[i]) begin
      step("t2.gap", 1'b0, 8'd99, 1'b0, 1'b0);
      step("t2", 1'b1, 8'(words1[i]), 1'b0, 1'b0);
    end
    repeat (5) step("t2.bp", 1'b1, 8'd77, 1'b0, 1'b0);
    chk("t2.stable", int'(out_sum), 100);
    step("t2.release", 1'b1, 8'd77, 1'b1, 1'b0);
    step("t2.idle", 1'b0, 8'd0, 1'b0, 1'b0);

    // Overflow: 4 x 255 = 1020 exceeds 511.
    repeat (4) step("t3", 1'b1, 8'd255, 1'b0, 1'b0);
`ifdef SUM_ACCUMULATOR_SAT_EN
    chk("t3.sat", int'(out_sum), 511);
`else
    chk("t3.wrap", int'(out_sum), 508);
`endif
    chk("t3.ovf", int'(ovf), 1);
    step("t3.release", 1'b0, 8'd0, 1'b1, 1'b0);

    // Clear mid-block drops the same-cycle word.
    step("t4", 1'b1, 8'd5, 1'b0, 1'b0);
    step("t4", 1'b1, 8'd6, 1'b0, 1'b0);
    step("t4.clear", 1'b1, 8'd7, 1'b0, 1'b1);
    chk("t4.cnt0", int'(sample_cnt), 0);
    repeat (4) step("t4.next", 1'b1, 8'd1, 1'b0, 1'b0);
    chk("t4.sum4", int'(out_sum), 4);
    // Clear also beats an output handshake.
    step("t4.clrdone", 1'b0, 8'd0, 1'b1, 1'b1);

    // Single-word blocks on the COUNT=1 instance.
    c1_in_valid = 1; c1_in_data = 8'd200; c1_out_ready = 1;
    step("t5.idle", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t5.v1", int'(c1_out_valid), 1);
    chk("t5.s1", int'(c1_out_sum), 200);
    chk("t5.cnt1", int'(c1_sample_cnt), 1);
    chk("t5.rdy1", int'(c1_in_ready), 0);
    c1_in_data = 8'd17;
    step("t5.idle", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t5.drop", int'(c1_out_valid), 0);
    chk("t5.rdy", int'(c1_in_ready), 1);
    step("t5.idle", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t5.v2", int'(c1_out_valid), 1);
    chk("t5.s2", int'(c1_out_sum), 17);
    chk("t5.ovf", int'(c1_ovf), 0);
    c1_in_valid = 0;
    step("t5.idle", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t5.end", int'(c1_out_valid), 0);
    c1_out_ready = 0;

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      step("rnd", 1'($urandom_range(0, 9) < 7), d,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end
    step("rnd.flush", 1'b0, 8'd0, 1'b1, 1'b1);

    // Asynchronous reset while holding a result.
    foreach (words1[i]) step("t6", 1'b1, 8'(words1[i]), 1'b0, 1'b0);
    chk("t6.sum100", int'(out_sum), 100);
    in_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6.async_valid", int'(out_valid), 0);
    chk("t6.async_sum", int'(out_sum), 0);
    chk("t6.async_cnt", int'(sample_cnt), 0);
    chk("t6.async_ready", int'(in_ready), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t6.after", 1'b1, 8'd3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage for the 8-bit adder: consumes each 8-bit sum word and accumulates COUNT consecutive words into a wider running total.
- Presents the completed block total on a valid/ready output port, then clears itself for the next block.
- Provides the registered, multi-sample result that the combinational adder cannot produce on its own.

Parameters:
ACC_W, 16, accumulator/result width in bits; legal range 9..32.
COUNT, 4, number of input words summed per output block; legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort; drops the partial or held block.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept in_data this cycle.
in_data  input  8  adder sum word, treated as unsigned.
out_valid  output  1  out_sum holds a completed block total.
out_ready  input  1  consumer accepts out_sum this cycle.
out_sum  output  ACC_W  accumulated total of COUNT words.
ovf  output  1  total exceeded 2^ACC_W-1 during the current block.
sample_cnt  output  8  words accepted so far in the current block.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, sample_cnt=0, out_valid=0, ovf=0, out_sum=0. in_ready=1 immediately after reset deasserts.
- States:
  - IDLE: acc=0 and cnt=0.
  - ACCUM: a partial block is in progress.
  - DONE: the total is held for the consumer.
- in_ready = (state != DONE), a combinational decode of the registered state.
- Accept occurs when in_valid && in_ready.
  - On accept: acc <= acc + {zero-extend in_data}, computed at ACC_W+1 bits. Bit ACC_W is the carry.
  - If the carry is set, ovf <= 1. ovf is sticky until the block ends.
  - Default (no SAT_EN): wrap, keeping the low ACC_W bits.
- Transitions:
  - IDLE/ACCUM, accept with cnt == COUNT-1 -> DONE. The next cycle has out_valid=1 and out_sum = the final acc (including this word). Latency is 1 cycle after the last accept.
  - IDLE, accept with cnt < COUNT-1 -> ACCUM, cnt+1.
  - ACCUM, accept with cnt < COUNT-1 -> stays in ACCUM, cnt+1.
  - Any state with no accept holds. in_valid=0 gaps of any length are allowed.
  - DONE, out_ready=1 -> IDLE. That edge clears acc, cnt and ovf, and out_valid drops.
  - DONE, out_ready=0 -> hold. out_sum and ovf stay stable and no input is accepted.
- COUNT=1: every accept goes directly to DONE.
- Words are never accepted in DONE, including the cycle in which out_ready is high. The next block's first word is accepted in the following cycle, so the throughput is COUNT words per COUNT+1 cycles at best.
- clear:
  - Any state -> IDLE, with acc, cnt, ovf and out_valid cleared.
  - clear has priority over a same-cycle accept, which is discarded.
  - clear has priority over a same-cycle out handshake; the result is considered lost.
- sample_cnt reads COUNT while in DONE and 0 in IDLE.
- rst mid-block or in DONE: all state is discarded immediately, without waiting for a clock edge.

Optional Feature:
SUM_ACCUMULATOR_SAT_EN
- Defined: on carry, acc saturates to all-ones (2^ACC_W-1) and stays saturated for the rest of the block. ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W. ovf is set, and the wrapped value is reported.

Test Plan:
1. Defaults: rst pulse, then in_data 10,20,30,40 back-to-back with out_ready=0 -> out_valid=1 one cycle after the 4th accept, out_sum=100, ovf=0, in_ready=0 while held. Then out_ready=1 -> IDLE with in_ready=1.
2. Gaps and backpressure: same words with in_valid toggling every other cycle, out_ready held low 5 cycles -> out_sum=100 stable for all 5 cycles; no extra words absorbed.
3. Overflow, ACC_W=9, COUNT=4: words 255,255,255,255 (sum 1020) -> wrap build gives out_sum=1020 mod 512=508 with ovf=1; SAT_EN build gives out_sum=511 with ovf=1.
4. clear mid-block: accept 5,6, then clear asserted with in_valid=1 and in_data=7 -> word 7 dropped, sample_cnt=0. Following block 1,1,1,1 -> out_sum=4.
5. COUNT=1: words 200 and 17, each consumed with out_ready=1 -> two results, 200 then 17, each one cycle after its accept.
6. Async reset in DONE: hold out_sum=100, assert rst between clock edges -> out_valid=0 and out_sum=0 before the next edge.
